// File: rtl/control_unit.sv
// control_unit: instruction-sequencing FSM for the processor datapath.
//
// A 9-bit instruction {op, rx, ry} is latched from din[8:0] when run is high
// in T0. The FSM then steps through T1..T3 and drives the bus-source selects
// and the sink load enables one phase at a time. All outputs are Moore decodes
// of the state register and IR. Both are cleared asynchronously by resetn, so
// the outputs drop to zero without waiting for a clock edge.
//
// Ports:
//   clk     in   system clock, rising-edge state updates
//   resetn  in   asynchronous active-low reset
//   run     in   start request, sampled only in T0
//   din     in   [15:0] external data; din[8:0] is the instruction at fetch
//   din_en  out  bus source = din
//   gout    out  bus source = G
//   rout    out  [2:0] register index driven onto the bus
//   rin     out  [7:0] one-hot register load enables
//   ain     out  load operand register A
//   gin     out  load G with A +/- bus
//   addsub  out  0 = add, 1 = subtract
//   done    out  instruction completes this cycle
//   busy    out  FSM is not in T0
module control_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic [15:0] din,
    output logic        din_en,
    output logic        gout,
    output logic [2:0]  rout,
    output logic [7:0]  rin,
    output logic        ain,
    output logic        gin,
    output logic        addsub,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        StT0 = 2'd0,
        StT1 = 2'd1,
        StT2 = 2'd2,
        StT3 = 2'd3
    } state_e;

    localparam logic [2:0] OpMv  = 3'b000;
    localparam logic [2:0] OpMvi = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b011;

    state_e     state_q, state_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] op, rx, ry;
    logic       is_alu;

    assign op     = ir_q[8:6];
    assign rx     = ir_q[5:3];
    assign ry     = ir_q[2:0];
    assign is_alu = (op == OpAdd) || (op == OpSub);

    // Next-state logic. IR only changes at the T0 fetch edge.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            StT0: begin
                if (run) begin
                    ir_d    = din[8:0];
                    state_d = StT1;
                end
            end
            StT1:    state_d = is_alu ? StT2 : StT0;
            StT2:    state_d = StT3;
            StT3:    state_d = StT0;
            default: state_d = StT0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StT0;
            ir_q    <= 9'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Moore output decode; anything not set for a state stays zero.
    always_comb begin
        din_en = 1'b0;
        gout   = 1'b0;
        rout   = 3'd0;
        rin    = 8'd0;
        ain    = 1'b0;
        gin    = 1'b0;
        addsub = 1'b0;
        done   = 1'b0;
        busy   = (state_q != StT0);
        unique case (state_q)
            StT0: ;
            StT1: begin
                if (op == OpMv) begin
                    rout = ry;
                    rin  = 8'd1 << rx;
                    done = 1'b1;
                end else if (op == OpMvi) begin
                    din_en = 1'b1;
                    rin    = 8'd1 << rx;
                    done   = 1'b1;
                end else if (is_alu) begin
                    rout = rx;
                    ain  = 1'b1;
                end else begin
                    // Opcodes 100-111 retire immediately with no side effects.
                    done = 1'b1;
                end
            end
            StT2: begin
                rout   = ry;
                gin    = 1'b1;
                addsub = op[0];
            end
            StT3: begin
                gout = 1'b1;
                rin  = 8'd1 << rx;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    typedef struct packed {
        logic       din_en;
        logic       gout;
        logic [2:0] rout;
        logic [7:0] rin;
        logic       ain;
        logic       gin;
        logic       addsub;
        logic       done;
        logic       busy;
    } out_t;

    typedef struct {
        logic        run;
        logic [15:0] din;
        out_t        exp;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        run;
    logic [15:0] din;
    logic        din_en, gout, ain, gin, addsub, done, busy;
    logic [2:0]  rout;
    logic [7:0]  rin;

    out_t act;
    assign act = {din_en, gout, rout, rin, ain, gin, addsub, done, busy};

    int checks = 0;
    int errors = 0;

    out_t sb[$];
    vec_t vecs[$];

    control_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .run    (run),
        .din    (din),
        .din_en (din_en),
        .gout   (gout),
        .rout   (rout),
        .rin    (rin),
        .ain    (ain),
        .gin    (gin),
        .addsub (addsub),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t o(logic den, logic go, logic [2:0] ro, logic [7:0] ri,
                               logic a, logic g, logic as, logic d, logic b);
        out_t r;
        r = {den, go, ro, ri, a, g, as, d, b};
        return r;
    endfunction

    function automatic void add_vec(logic r, logic [15:0] d, out_t e);
        vec_t v;
        v.run = r;
        v.din = d;
        v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, out_t got, out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (den,gout,rout,rin,ain,gin,as,done,busy)",
                     name, got, exp);
        end
    endtask

    // Drive at the current point, push the expectation, compare after the edge.
    task automatic apply(string name, logic r, logic [15:0] d, out_t e);
        out_t x;
        run = r;
        din = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty got %b required an entry", name, act);
        end else begin
            x = sb.pop_front();
            check(name, act, x);
        end
    endtask

    task automatic step(string name, logic r, logic [15:0] d, out_t e);
        @(negedge clk);
        apply(name, r, d, e);
    endtask

    // Per-cycle invariants while out of reset.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            checks++;
            if ((din_en && gout) || !$onehot0(rin) ||
                ((32'(ain) + 32'(gin) + 32'(rin != 8'd0)) > 1) ||
                (done && !busy) ||
                (!busy && (act != '0))) begin
                errors++;
                $display("FAIL invariant: got %b required legal combination", act);
            end
        end
    end

    out_t z;

    initial begin
        z      = '0;
        run    = 1'b0;
        din    = 16'd0;
        resetn = 1'b0;
        #1;
        check("reset_outputs", act, z);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        //         den go rout rin    ain gin as done busy
        add_vec(1, 16'h0050, o(1, 0, 3'd0, 8'h04, 0, 0, 0, 1, 1)); // mvi R2 T1
        add_vec(0, 16'h1234, z);
        add_vec(1, 16'h0029, o(0, 0, 3'd1, 8'h20, 0, 0, 0, 1, 1)); // mv R5,R1 T1
        add_vec(0, 16'h0000, z);
        add_vec(1, 16'h0087, o(0, 0, 3'd0, 8'h00, 1, 0, 0, 0, 1)); // add R0,R7 T1
        add_vec(0, 16'h0000, o(0, 0, 3'd7, 8'h00, 0, 1, 0, 0, 1)); // T2
        add_vec(0, 16'h0000, o(0, 1, 3'd0, 8'h01, 0, 0, 0, 1, 1)); // T3
        add_vec(0, 16'h0000, z);
        add_vec(1, 16'h00DC, o(0, 0, 3'd3, 8'h00, 1, 0, 0, 0, 1)); // sub R3,R4 T1
        add_vec(1, 16'h01FF, o(0, 0, 3'd4, 8'h00, 0, 1, 1, 0, 1)); // T2, run ignored
        add_vec(0, 16'h0000, o(0, 1, 3'd0, 8'h08, 0, 0, 0, 1, 1)); // T3
        add_vec(0, 16'h0000, z);
        add_vec(1, 16'h0140, o(0, 0, 3'd0, 8'h00, 0, 0, 0, 1, 1)); // nop 101
        add_vec(0, 16'h0000, z);
        add_vec(1, 16'h0169, o(0, 0, 3'd0, 8'h00, 0, 0, 0, 1, 1)); // op 101, fields set
        // Continuous run: mv, add, mvi back to back.
        add_vec(1, 16'h0029, z);                                   // leaves T1 regardless
        add_vec(1, 16'h0029, o(0, 0, 3'd1, 8'h20, 0, 0, 0, 1, 1)); // mv done
        add_vec(1, 16'h0087, z);
        add_vec(1, 16'h0087, o(0, 0, 3'd0, 8'h00, 1, 0, 0, 0, 1));
        add_vec(0, 16'h0000, o(0, 0, 3'd7, 8'h00, 0, 1, 0, 0, 1)); // run toggled in T1
        add_vec(1, 16'h0050, o(0, 1, 3'd0, 8'h01, 0, 0, 0, 1, 1)); // add done
        add_vec(1, 16'h0050, z);
        add_vec(1, 16'h0050, o(1, 0, 3'd0, 8'h04, 0, 0, 0, 1, 1)); // mvi done
        add_vec(0, 16'h0000, z);

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i].run, vecs[i].din, vecs[i].exp);

        // Reset during T2 of an add: outputs clear without a clock edge.
        step("abort_t1", 1, 16'h0087, o(0, 0, 3'd0, 8'h00, 1, 0, 0, 0, 1));
        step("abort_t2", 0, 16'h0000, o(0, 0, 3'd7, 8'h00, 0, 1, 0, 0, 1));
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset", act, z);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++)
            step($sformatf("idle%0d", i), 0, 16'h0000, z);

        // First edge after release can fetch.
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        apply("fetch_after_reset", 1, 16'h0029, o(0, 0, 3'd1, 8'h20, 0, 0, 0, 1, 1));
        step("post_fetch_idle", 0, 16'h0000, z);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
